// File: rtl/reg_write_arbiter.sv
// Round-robin register-file write arbiter: one combinational grant per cycle, with one registered write stage.
// Optional same-cycle read bypass of the in-flight write is enabled by defining REGARB_BYPASS_EN.
module reg_write_arbiter #(
   parameter int WIDTH = 32,
   parameter int AW    = 4,
   parameter int NREQ  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]      grant,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
`ifdef REGARB_BYPASS_EN
   output logic [WIDTH-1:0]     wr_data,
   input  logic [AW-1:0]        byp_addr,
   output logic                 byp_hit,
   output logic [WIDTH-1:0]     byp_data
`else
   output logic [WIDTH-1:0]     wr_data
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]    r_ptr;
   logic             r_wr_en;
   logic [AW-1:0]    r_wr_addr;
   logic [WIDTH-1:0] r_wr_data;

   logic [NREQ-1:0]  w_grant;
   logic             w_found;
   logic [PW-1:0]    w_gidx;
   logic [PW-1:0]    w_ptr_nxt;
   logic [AW-1:0]    w_sel_addr;
   logic [WIDTH-1:0] w_sel_data;
   int               w_idx;

   // Search ptr, ptr+1, ... with wrap; reset and stall mask every grant.
   always_comb begin
      w_grant    = '0;
      w_found    = 1'b0;
      w_gidx     = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      w_idx      = 0;
      if (!rst && !stall) begin
         for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && req[w_idx]) begin
               w_found          = 1'b1;
               w_grant[w_idx]   = 1'b1;
               w_gidx           = PW'(w_idx);
               w_sel_addr       = req_addr[w_idx*AW +: AW];
               w_sel_data       = req_data[w_idx*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_comb begin
      w_ptr_nxt = w_gidx + 1'b1;
      if (w_gidx == PW'(NREQ-1)) w_ptr_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_found;
         if (w_found) begin
            r_ptr     <= w_ptr_nxt;
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
         end
      end
   end

   assign grant   = w_grant;
   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;

`ifdef REGARB_BYPASS_EN
   assign byp_hit  = r_wr_en && (r_wr_addr == byp_addr);
   assign byp_data = r_wr_data;
`endif

endmodule
